// File: rtl/control_unit.sv
// Hardwired control unit for a multi-cycle 32-bit datapath.
// One state per T-step: a common fetch (T0..T2), then an opcode-dependent
// execute sequence (T3..T7). Strobes are decoded combinationally from the
// present state and IR[31:27], so each one is high for the whole cycle of
// its state.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   T0     | PC -> MAR, PC+1 -> Z
//   T1     | Z -> PC, memory read into MDR
//   T2     | MDR -> IR
//   T3..T7 | execute steps, sequence selected by IR[31:27]
//   HALT   | halted; no strobes, Run low; left only through clear_n
module control_unit (
   input  logic        Clock,
   input  logic        clear_n,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        Stop,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        PCin,
   output logic        PCout,
   output logic        IncPC,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        Write,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        HIout,
   output logic        LOin,
   output logic        LOout,
   output logic        Cout,
   output logic        CONin,
   output logic        Inportout,
   output logic        Outportin,
   output logic [4:0]  opcode,
   output logic        Run
);

   typedef enum logic [3:0] {
      S_T0   = 4'd0,
      S_T1   = 4'd1,
      S_T2   = 4'd2,
      S_T3   = 4'd3,
      S_T4   = 4'd4,
      S_T5   = 4'd5,
      S_T6   = 4'd6,
      S_T7   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;

   state_t     state_q, state_d;
   logic       stop_pending_q, stop_pending_d;
   state_t     last_state;
   logic [4:0] op;
   logic       unused_ir_low;

   assign op            = IR[31:27];
   assign unused_ir_low = ^IR[26:0];

   logic is_ld, is_ldi, is_st, is_alur, is_alui, is_muldiv, is_negnot;
   logic is_br, is_jr, is_in, is_out, is_mfhi, is_mflo, is_halt;

   // Instruction class decode; any opcode not matched executes as nop.
   always_comb begin
      is_ld     = (op == 5'd0);
      is_ldi    = (op == 5'd1);
      is_st     = (op == 5'd2);
      is_alur   = (op >= 5'd3)  && (op <= 5'd10);
      is_alui   = (op >= 5'd11) && (op <= 5'd13);
      is_muldiv = (op == 5'd14) || (op == 5'd15);
      is_negnot = (op == 5'd16) || (op == 5'd17);
      is_br     = (op == 5'd18);
      is_jr     = (op == 5'd19);
      is_in     = (op == 5'd21);
      is_out    = (op == 5'd22);
      is_mfhi   = (op == 5'd23);
      is_mflo   = (op == 5'd24);
      is_halt   = (op == 5'd26);
   end

   // Final T-state of the current instruction.
   always_comb begin
      last_state = S_T3;
      if (is_ld || is_st)
         last_state = S_T7;
      else if (is_ldi || is_alur || is_alui)
         last_state = S_T5;
      else if (is_muldiv || is_br)
         last_state = S_T6;
      else if (is_negnot)
         last_state = S_T4;
   end

   // Sequencing: advance one T-step per cycle; at the instruction boundary
   // go to HALT for a halt opcode or a stop request (including one arriving
   // in the final cycle itself), else back to T0.
   always_comb begin
      state_d        = state_q;
      stop_pending_d = stop_pending_q | Stop;
      if (state_q != S_HALT) begin
         if (state_q == last_state) begin
            if (is_halt || stop_pending_q || Stop)
               state_d = S_HALT;
            else
               state_d = S_T0;
         end else begin
            state_d = state_t'(state_q + 4'd1);
         end
      end
   end

   // State and sticky stop request registers.
   always_ff @(posedge Clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q        <= S_T0;
         stop_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         stop_pending_q <= stop_pending_d;
      end
   end

   assign Run = (state_q != S_HALT);

   // Strobe decode; forced low while clear_n is asserted so an abandoned
   // instruction drives nothing even though the state already reads T0.
   always_comb begin
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      PCin = 1'b0; PCout = 1'b0; IncPC = 1'b0; IRin = 1'b0; MARin = 1'b0;
      MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0;
      Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
      HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0;
      Cout = 1'b0; CONin = 1'b0; Inportout = 1'b0; Outportin = 1'b0;
      opcode = 5'b00000;
      if (clear_n) begin
         case (state_q)
            S_T0: begin
               PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
               Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
               MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
               if (is_alur || is_alui) begin
                  Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
               end else if (is_ld || is_ldi || is_st) begin
                  Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
               end else if (is_muldiv) begin
                  Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
               end else if (is_negnot) begin
                  Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
               end else if (is_br) begin
                  Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
               end else if (is_jr) begin
                  Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
               end else if (is_in) begin
                  Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end else if (is_out) begin
                  Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1;
               end else if (is_mfhi) begin
                  HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end else if (is_mflo) begin
                  LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end
            end
            S_T4: begin
               if (is_alur) begin
                  Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
               end else if (is_alui) begin
                  Cout = 1'b1; Zin = 1'b1;
                  if (op == 5'd11)      opcode = OP_ADD;
                  else if (op == 5'd12) opcode = OP_AND;
                  else                  opcode = OP_OR;
               end else if (is_ld || is_ldi || is_st) begin
                  Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD;
               end else if (is_muldiv) begin
                  Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
               end else if (is_negnot) begin
                  Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end else if (is_br) begin
                  PCout = 1'b1; Yin = 1'b1;
               end
            end
            S_T5: begin
               if (is_alur || is_alui || is_ldi) begin
                  Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end else if (is_ld || is_st) begin
                  Zlowout = 1'b1; MARin = 1'b1;
               end else if (is_muldiv) begin
                  Zlowout = 1'b1; LOin = 1'b1;
               end else if (is_br) begin
                  Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD;
               end
            end
            S_T6: begin
               if (is_ld) begin
                  Read = 1'b1; MDRin = 1'b1;
               end else if (is_st) begin
                  Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
               end else if (is_muldiv) begin
                  Zhighout = 1'b1; HIin = 1'b1;
               end else if (is_br && CON_FF) begin
                  Zlowout = 1'b1; PCin = 1'b1;
               end
            end
            S_T7: begin
               if (is_ld) begin
                  MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end else if (is_st) begin
                  Write = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe/opcode/Run expectations
// written out by hand for each instruction sequence.
module tb_control_unit;

   logic        Clock = 1'b0;
   logic        clear_n = 1'b0;
   logic [31:0] IR = 32'd0;
   logic        CON_FF = 1'b0;
   logic        Stop = 1'b0;
   logic Gra, Grb, Grc, Rin, Rout, BAout, PCin, PCout, IncPC, IRin, MARin;
   logic MDRin, MDRout, Read, Write, Yin, Zin, Zlowout, Zhighout, HIin, HIout;
   logic LOin, LOout, Cout, CONin, Inportout, Outportin, Run;
   logic [4:0] opcode;

   int n_chk = 0;
   int n_pass = 0;

   control_unit dut (
      .Clock(Clock), .clear_n(clear_n), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
      .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
      .Cout(Cout), .CONin(CONin), .Inportout(Inportout), .Outportin(Outportin),
      .opcode(opcode), .Run(Run)
   );

   always #5 Clock = ~Clock;

   logic [26:0] strb;
   assign strb = {Gra, Grb, Grc, Rin, Rout, BAout, PCin, PCout, IncPC, IRin,
                  MARin, MDRin, MDRout, Read, Write, Yin, Zin, Zlowout,
                  Zhighout, HIin, HIout, LOin, LOout, Cout, CONin, Inportout,
                  Outportin};

   localparam logic [26:0] GRA   = 27'd1 << 26, GRB   = 27'd1 << 25;
   localparam logic [26:0] GRC   = 27'd1 << 24, RIN   = 27'd1 << 23;
   localparam logic [26:0] ROUT  = 27'd1 << 22, BAOUT = 27'd1 << 21;
   localparam logic [26:0] PCIN  = 27'd1 << 20, PCOUT = 27'd1 << 19;
   localparam logic [26:0] INCPC = 27'd1 << 18, IRIN  = 27'd1 << 17;
   localparam logic [26:0] MARIN = 27'd1 << 16, MDRIN = 27'd1 << 15;
   localparam logic [26:0] MDROUT= 27'd1 << 14, READ  = 27'd1 << 13;
   localparam logic [26:0] WRITE = 27'd1 << 12, YIN   = 27'd1 << 11;
   localparam logic [26:0] ZIN   = 27'd1 << 10, ZLO   = 27'd1 << 9;
   localparam logic [26:0] ZHI   = 27'd1 << 8,  HIIN  = 27'd1 << 7;
   localparam logic [26:0] HIOUT = 27'd1 << 6,  LOIN  = 27'd1 << 5;
   localparam logic [26:0] LOOUT = 27'd1 << 4,  COUT  = 27'd1 << 3;
   localparam logic [26:0] CONIN = 27'd1 << 2,  INPO  = 27'd1 << 1;
   localparam logic [26:0] OUTPI = 27'd1;
   localparam logic [26:0] NONE  = 27'd0;

   localparam logic [26:0] F0 = PCOUT | MARIN | INCPC | ZIN;
   localparam logic [26:0] F1 = ZLO | PCIN | READ | MDRIN;
   localparam logic [26:0] F2 = MDROUT | IRIN;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Called just after a falling edge: check this cycle, move to next falling edge.
   task automatic step_chk(input string tag, input logic [26:0] s, input logic [4:0] op,
                           input logic run);
      #1;
      check({tag, "_strb"}, {5'd0, strb}, {5'd0, s});
      check({tag, "_op"},   {27'd0, opcode}, {27'd0, op});
      check({tag, "_run"},  {31'd0, Run}, {31'd0, run});
      @(negedge Clock);
   endtask

   task automatic do_reset(input logic [31:0] ir, input logic con);
      @(negedge Clock);
      clear_n = 1'b0;
      IR      = ir;
      CON_FF  = con;
      Stop    = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      clear_n = 1'b1;
   endtask

   task automatic fetch_chk(input string tag);
      step_chk({tag, "_T0"}, F0, 5'd0, 1'b1);
      step_chk({tag, "_T1"}, F1, 5'd0, 1'b1);
      step_chk({tag, "_T2"}, F2, 5'd0, 1'b1);
   endtask

   function automatic logic [31:0] mk_ir(input logic [4:0] op);
      return {op, 27'h5A5A5A5};
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values while clear_n is low.
      IR = mk_ir(5'd3);
      #12;
      check("rst_strb", {5'd0, strb}, 32'd0);
      check("rst_op", {27'd0, opcode}, 32'd0);
      check("rst_run", {31'd0, Run}, 32'd1);

      // add
      do_reset(mk_ir(5'd3), 1'b0);
      fetch_chk("add");
      step_chk("add_T3", GRB | ROUT | YIN, 5'd0, 1'b1);
      step_chk("add_T4", GRC | ROUT | ZIN, 5'd3, 1'b1);
      step_chk("add_T5", ZLO | GRA | RIN, 5'd0, 1'b1);
      step_chk("add_back", F0, 5'd0, 1'b1);

      // st
      do_reset(mk_ir(5'd2), 1'b0);
      fetch_chk("st");
      step_chk("st_T3", GRB | BAOUT | YIN, 5'd0, 1'b1);
      step_chk("st_T4", COUT | ZIN, 5'd3, 1'b1);
      step_chk("st_T5", ZLO | MARIN, 5'd0, 1'b1);
      step_chk("st_T6", GRA | ROUT | MDRIN, 5'd0, 1'b1);
      step_chk("st_T7", WRITE, 5'd0, 1'b1);
      step_chk("st_back", F0, 5'd0, 1'b1);

      // br not taken, then taken
      do_reset(mk_ir(5'd18), 1'b0);
      fetch_chk("brn");
      step_chk("brn_T3", GRA | ROUT | CONIN, 5'd0, 1'b1);
      step_chk("brn_T4", PCOUT | YIN, 5'd0, 1'b1);
      step_chk("brn_T5", COUT | ZIN, 5'd3, 1'b1);
      step_chk("brn_T6", NONE, 5'd0, 1'b1);
      step_chk("brn_back", F0, 5'd0, 1'b1);
      do_reset(mk_ir(5'd18), 1'b1);
      fetch_chk("bry");
      step_chk("bry_T3", GRA | ROUT | CONIN, 5'd0, 1'b1);
      step_chk("bry_T4", PCOUT | YIN, 5'd0, 1'b1);
      step_chk("bry_T5", COUT | ZIN, 5'd3, 1'b1);
      step_chk("bry_T6", ZLO | PCIN, 5'd0, 1'b1);
      step_chk("bry_back", F0, 5'd0, 1'b1);

      // ld with Stop pulsed during T4
      do_reset(mk_ir(5'd0), 1'b0);
      fetch_chk("ld");
      step_chk("ld_T3", GRB | BAOUT | YIN, 5'd0, 1'b1);
      Stop = 1'b1;
      step_chk("ld_T4", COUT | ZIN, 5'd3, 1'b1);
      Stop = 1'b0;
      step_chk("ld_T5", ZLO | MARIN, 5'd0, 1'b1);
      step_chk("ld_T6", READ | MDRIN, 5'd0, 1'b1);
      step_chk("ld_T7", MDROUT | GRA | RIN, 5'd0, 1'b1);
      step_chk("ld_halt", NONE, 5'd0, 1'b0);
      step_chk("ld_halt2", NONE, 5'd0, 1'b0);

      // Stop in the final cycle of addi halts at that boundary
      do_reset(mk_ir(5'd11), 1'b0);
      fetch_chk("addi");
      step_chk("addi_T3", GRB | ROUT | YIN, 5'd0, 1'b1);
      step_chk("addi_T4", COUT | ZIN, 5'd3, 1'b1);
      Stop = 1'b1;
      step_chk("addi_T5", ZLO | GRA | RIN, 5'd0, 1'b1);
      Stop = 1'b0;
      step_chk("addi_halt", NONE, 5'd0, 1'b0);

      // andi / ori ALU select in T4
      do_reset(mk_ir(5'd12), 1'b0);
      fetch_chk("andi");
      step_chk("andi_T3", GRB | ROUT | YIN, 5'd0, 1'b1);
      step_chk("andi_T4", COUT | ZIN, 5'd5, 1'b1);
      do_reset(mk_ir(5'd13), 1'b0);
      fetch_chk("ori");
      step_chk("ori_T3", GRB | ROUT | YIN, 5'd0, 1'b1);
      step_chk("ori_T4", COUT | ZIN, 5'd6, 1'b1);

      // mul
      do_reset(mk_ir(5'd14), 1'b0);
      fetch_chk("mul");
      step_chk("mul_T3", GRA | ROUT | YIN, 5'd0, 1'b1);
      step_chk("mul_T4", GRB | ROUT | ZIN, 5'd14, 1'b1);
      step_chk("mul_T5", ZLO | LOIN, 5'd0, 1'b1);
      step_chk("mul_T6", ZHI | HIIN, 5'd0, 1'b1);
      step_chk("mul_back", F0, 5'd0, 1'b1);

      // not
      do_reset(mk_ir(5'd17), 1'b0);
      fetch_chk("not");
      step_chk("not_T3", GRB | ROUT | ZIN, 5'd17, 1'b1);
      step_chk("not_T4", ZLO | GRA | RIN, 5'd0, 1'b1);
      step_chk("not_back", F0, 5'd0, 1'b1);

      // single-step ops
      do_reset(mk_ir(5'd19), 1'b0);
      fetch_chk("jr");
      step_chk("jr_T3", GRA | ROUT | PCIN, 5'd0, 1'b1);
      step_chk("jr_back", F0, 5'd0, 1'b1);
      do_reset(mk_ir(5'd22), 1'b0);
      fetch_chk("out");
      step_chk("out_T3", GRA | ROUT | OUTPI, 5'd0, 1'b1);
      step_chk("out_back", F0, 5'd0, 1'b1);
      do_reset(mk_ir(5'd21), 1'b0);
      fetch_chk("in");
      step_chk("in_T3", INPO | GRA | RIN, 5'd0, 1'b1);
      do_reset(mk_ir(5'd24), 1'b0);
      fetch_chk("mflo");
      step_chk("mflo_T3", LOOUT | GRA | RIN, 5'd0, 1'b1);
      step_chk("mflo_back", F0, 5'd0, 1'b1);

      // illegal opcode runs as nop
      do_reset(mk_ir(5'd31), 1'b0);
      fetch_chk("ill");
      step_chk("ill_T3", NONE, 5'd0, 1'b1);
      step_chk("ill_back", F0, 5'd0, 1'b1);

      // halt: absorbing for 20 cycles, then async reset
      do_reset(mk_ir(5'd26), 1'b0);
      fetch_chk("hlt");
      step_chk("hlt_T3", NONE, 5'd0, 1'b1);
      for (int i = 0; i < 20; i++)
         step_chk($sformatf("hlt_c%0d", i), NONE, 5'd0, 1'b0);
      #2 clear_n = 1'b0;
      #1;
      check("hlt_rst_strb", {5'd0, strb}, 32'd0);
      check("hlt_rst_run", {31'd0, Run}, 32'd1);

      // reset mid-instruction abandons it
      do_reset(mk_ir(5'd3), 1'b0);
      fetch_chk("mid");
      step_chk("mid_T3", GRB | ROUT | YIN, 5'd0, 1'b1);
      #2 clear_n = 1'b0;
      #1;
      check("mid_rst_strb", {5'd0, strb}, 32'd0);
      check("mid_rst_op", {27'd0, opcode}, 32'd0);
      check("mid_rst_run", {31'd0, Run}, 32'd1);
      @(negedge Clock);
      step_chk("mid_hold", NONE, 5'd0, 1'b1);
      clear_n = 1'b1;
      step_chk("mid_T0", F0, 5'd0, 1'b1);
      step_chk("mid_T1", F1, 5'd0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
